dcache_2way_wb: RTL and testbench
=================================

// Module: dcache_2way_wb
// PURPOSE
// Data cache between pipeline MEM stage and memory controller. 2-way set-assoc, write-back, write-allocate, LRU.
// Serves LW/SW/LL/SC from the datapath; dhit is the only MEM-stage release. On halt, writes back all dirty
// blocks, then raises flushed. Owns the LL/SC link register.
// PARAMETERS
// SETS    8  sets; index width = $clog2(SETS)
// WAYS    2  fixed; LRU is one bit per set
// BLKWDS  2  words per block; block-offset width 1
// PORTS
// CLK        in   1   clock
// RST        in   1   reset, synchronous, active-high
// dmemREN    in   1   datapath read request (LW, LL)
// dmemWEN    in   1   datapath write request (SW, SC)
// datomic    in   1   qualifies REN as LL, WEN as SC
// dmemaddr   in   32  word address; [1:0] ignored
// dmemstore  in   32  store data
// halt       in   1   datapath halted; start flush
// dhit       out  1   request complete this cycle
// dmemload   out  32  load data; SC: 1=success, 0=fail
// flushed    out  1   flush complete, held until reset
// dREN       out  1   memory read request
// dWEN       out  1   memory write request
// daddr      out  32  memory word address
// dstore     out  32  memory write data
// dwait      in   1   memory busy; transfer completes in the cycle dwait=0
// dload      in   32  memory read data
// BEHAVIOUR
// - Address split: tag=[31:3+log2(SETS)], idx=[2+log2(SETS):3], blkoff=[2], byte=[1:0].
// - Reset (sync, any state, mid-transfer included): all valid/dirty/LRU=0, link invalid, state IDLE.
//   Outputs 0: dhit, dmemload, flushed, dREN, dWEN, daddr, dstore.
// - Hit, IDLE only, combinational: valid && tag match in either way -> dhit=1 same cycle. Read: dmemload=word.
//   Write: on clock, word<=dmemstore, dirty<=1. Any hit sets LRU[idx] to the other way.
// - REN and WEN both high is treated as a write. No request -> dhit=0, no state change.
// - Miss: victim=LRU[idx]. valid&&dirty -> WB0, else LD0. dhit stays 0 until the replayed hit in IDLE.
// - WB0/WB1: dWEN=1, daddr={victim tag,idx,w,2'b00} for w=0/1, dstore=victim word. Advance on ~dwait.
//   WB1 -> LD0.
// - LD0/LD1: dREN=1, daddr={req tag,idx,w,2'b00}; on ~dwait write word w. LD1 done: valid=1, dirty=0,
//   tag set -> IDLE. Request then hits; minimum miss latency = transfers + 1 cycle.
// - LL hit: load as LW; link<={addr[31:2],valid=1}.
// - SC with link valid && link addr==dmemaddr[31:2]: normal write path incl. miss; on hit dmemload=1,
//   link cleared.
// - SC with link invalid or mismatched: dhit=1 in IDLE same cycle, dmemload=0, no write, no miss.
// - Any write hit whose addr == link addr clears link. Reads never clear it.
// - Flush: halt seen in IDLE, no request pending -> FLUSH. Counter f=0..2*SETS-1 walks (idx=f>>1, way=f[0]).
//   Dirty frame: 2 write-backs, as WB0/WB1. Clean frame: 1 cycle skip.
//   After last frame -> FLUSHED: flushed=1, dREN=dWEN=0, stays until RST.
// - halt during a miss: finish the miss first. Requests in FLUSH/FLUSHED: dhit=0.
// - dREN and dWEN never both 1. daddr/dstore stable while dwait=1.
// - States: IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, FLUSHED.
// STRUCTURE
// - cpu_types_pkg: dcachef_t address struct, dcache_frame_t {valid,dirty,tag,data[BLKWDS]}, state enum.
// - One sub-module: dcache_link_reg (LL set, SC check, write-snoop clear). Frame array and FSM stay in the top.
// TESTING
// 1 Cold LW 0x0000_0040, dload=0xDEAD_BEEF/0x1 -> 2 dREN reads at 0x40 and 0x44, then dhit, dmemload=0xDEADBEEF.
// 2 SW 0x40=0x5; LW 0x80, then 0xC0 (same idx), forcing eviction of 0x40 -> dWEN 0x40=0x5, 0x44, then
//   dREN 0xC0, 0xC4.
// 3 LL 0x100; SC 0x100 data 7 -> dmemload=1, 0x100 reads 7.
//   LL 0x100; SW 0x100; SC 0x100 -> dmemload=0, value unchanged.
// 4 SC 0x200 with no prior LL -> dhit in 1 cycle, dmemload=0, no dREN/dWEN.
// 5 Dirty lines in sets 0 and 7 of way 1; halt=1 -> exactly 4 dWEN transfers, flushed=1 after 2*SETS frames.
// 6 RST asserted during LD1 with dwait=1 -> next cycle IDLE, all outputs 0; prior hit address now misses.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the 2-way write-back data cache: address split, frame layout, FSM states.
package cpu_types_pkg;

    localparam int SETS   = 8;
    localparam int WAYS   = 2;
    localparam int BLKWDS = 2;
    localparam int IDXW   = $clog2(SETS);
    localparam int TAGW   = 32 - 3 - IDXW;

    localparam logic [IDXW:0] FCNT_LAST = (IDXW + 1)'(2 * SETS - 1);
    localparam logic [IDXW:0] FCNT_ONE  = (IDXW + 1)'(1);

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [IDXW-1:0] idx;
        logic            blkoff;
        logic [1:0]      bytoff;
    } dcachef_t;

    typedef struct packed {
        logic                         valid;
        logic                         dirty;
        logic [TAGW-1:0]              tag;
        logic [BLKWDS-1:0][31:0]      data;
    } dcache_frame_t;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, FLUSHED
    } dstate_t;

    function automatic logic [31:0] blk_addr(input logic [TAGW-1:0] tag,
                                             input logic [IDXW-1:0] idx,
                                             input logic            w);
        return {tag, idx, w, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_link_reg.sv
// LL/SC link register: set by a load-linked hit, cleared by any write hit to the linked word.
module dcache_link_reg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ll_set_i,
    input  logic        wr_hit_i,
    input  logic [29:0] addr_i,
    output logic        match_o
);

    logic        valid_q;
    logic [29:0] addr_q;

    assign match_o = valid_q && (addr_q == addr_i);

    // A write snoop wins over a new link; SC success also goes through the snoop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= 30'd0;
        end else if (wr_hit_i && match_o) begin
            valid_q <= 1'b0;
        end else if (ll_set_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
        end else begin
            valid_q <= valid_q;
        end
    end

endmodule

// File: rtl/dcache_2way_wb.sv
// 2-way set-associative write-back/write-allocate data cache with LRU, LL/SC and halt-time flush.
module dcache_2way_wb
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

    dcache_frame_t   frames_q [WAYS][SETS];
    logic [SETS-1:0] lru_q;
    dstate_t         state_q, state_d;
    logic [IDXW:0]   fcnt_q, fcnt_d;
    logic            victim_q, victim_d;

    dcachef_t        req_s;
    dcache_frame_t   vic_frame_s, wb_frame_s, fl_frame_s;
    logic [WAYS-1:0] hit_w_s;
    logic            hit_way_s, req_any_s, sc_fail_s, link_match_s;
    logic            wb_fsm_s, wb_way_s, word_sel_s, fill_s, flast_s;
    logic [IDXW-1:0] wb_idx_s;
    logic            lru_upd_s, wr_hit_s, ll_set_s;
    logic            unused_s;

    assign req_s       = dcachef_t'(dmemaddr);
    assign unused_s    = ^req_s.bytoff;
    assign req_any_s   = dmemREN | dmemWEN;
    assign sc_fail_s   = dmemWEN & datomic & ~link_match_s;
    assign hit_way_s   = hit_w_s[1];
    assign vic_frame_s = frames_q[lru_q[req_s.idx]][req_s.idx];
    assign wb_fsm_s    = (state_q == FWB0) || (state_q == FWB1);
    assign wb_way_s    = wb_fsm_s ? fcnt_q[0] : victim_q;
    assign wb_idx_s    = wb_fsm_s ? fcnt_q[IDXW:1] : req_s.idx;
    assign wb_frame_s  = frames_q[wb_way_s][wb_idx_s];
    assign fl_frame_s  = frames_q[fcnt_q[0]][fcnt_q[IDXW:1]];
    assign word_sel_s  = (state_q == WB1) || (state_q == LD1) || (state_q == FWB1);
    assign fill_s      = ((state_q == LD0) || (state_q == LD1)) && !dwait;
    assign flast_s     = (fcnt_q == FCNT_LAST);

    dcache_link_reg u_link (
        .clk_i   (CLK),
        .rst_i   (RST),
        .ll_set_i(ll_set_s),
        .wr_hit_i(wr_hit_s),
        .addr_i  (dmemaddr[31:2]),
        .match_o (link_match_s)
    );

    // Tag compare in both ways of the requested set.
    always_comb begin
        hit_w_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_w_s[w] = frames_q[w][req_s.idx].valid && (frames_q[w][req_s.idx].tag == req_s.tag);
        end
    end

    // Next state, memory-side outputs and MEM-stage response.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        victim_d  = victim_q;
        dhit      = 1'b0;
        dmemload  = 32'd0;
        flushed   = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = 32'd0;
        dstore    = 32'd0;
        lru_upd_s = 1'b0;
        wr_hit_s  = 1'b0;
        ll_set_s  = 1'b0;

        case (state_q)
            WB0, WB1, FWB0, FWB1: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(wb_frame_s.tag, wb_idx_s, word_sel_s);
                dstore = wb_frame_s.data[word_sel_s];
            end
            LD0, LD1: begin
                dREN  = 1'b1;
                daddr = blk_addr(req_s.tag, req_s.idx, word_sel_s);
            end
            FLUSHED: flushed = 1'b1;
            default: flushed = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (req_any_s) begin
                    if (sc_fail_s) begin
                        dhit = 1'b1;
                    end else if (|hit_w_s) begin
                        dhit      = 1'b1;
                        lru_upd_s = 1'b1;
                        if (dmemWEN) begin
                            wr_hit_s = 1'b1;
                            dmemload = {31'd0, datomic};
                        end else begin
                            dmemload = frames_q[hit_way_s][req_s.idx].data[req_s.blkoff];
                            ll_set_s = datomic;
                        end
                    end else begin
                        victim_d = lru_q[req_s.idx];
                        state_d  = (vic_frame_s.valid && vic_frame_s.dirty) ? WB0 : LD0;
                    end
                end else if (halt) begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            WB0:  state_d = dwait ? WB0 : WB1;
            WB1:  state_d = dwait ? WB1 : LD0;
            LD0:  state_d = dwait ? LD0 : LD1;
            LD1:  state_d = dwait ? LD1 : IDLE;
            FLUSH: begin
                if (fl_frame_s.valid && fl_frame_s.dirty) begin
                    state_d = FWB0;
                end else if (flast_s) begin
                    state_d = FLUSHED;
                end else begin
                    fcnt_d = fcnt_q + FCNT_ONE;
                end
            end
            FWB0: state_d = dwait ? FWB0 : FWB1;
            FWB1: begin
                if (dwait) begin
                    state_d = FWB1;
                end else if (flast_s) begin
                    state_d = FLUSHED;
                end else begin
                    state_d = FLUSH;
                    fcnt_d  = fcnt_q + FCNT_ONE;
                end
            end
            FLUSHED: state_d = FLUSHED;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, flush walker and latched miss victim.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            fcnt_q   <= '0;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            victim_q <= victim_d;
        end
    end

    // Frame array and LRU: write hits, line fills, replacement bookkeeping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    frames_q[w][s] <= '0;
                end
            end
            lru_q <= '0;
        end else begin
            if (wr_hit_s) begin
                frames_q[hit_way_s][req_s.idx].data[req_s.blkoff] <= dmemstore;
                frames_q[hit_way_s][req_s.idx].dirty              <= 1'b1;
            end
            if (lru_upd_s) begin
                lru_q[req_s.idx] <= ~hit_way_s;
            end
            if (fill_s) begin
                frames_q[victim_q][req_s.idx].data[word_sel_s] <= dload;
                if (state_q == LD1) begin
                    frames_q[victim_q][req_s.idx].valid <= 1'b1;
                    frames_q[victim_q][req_s.idx].dirty <= 1'b0;
                    frames_q[victim_q][req_s.idx].tag   <= req_s.tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_2way_wb.sv
// Directed bench for dcache_2way_wb with a zero-wait memory model and hand-computed expectations.
module tb_dcache_2way_wb;

    logic        CLK, RST;
    logic        dmemREN, dmemWEN, datomic, halt;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;
    logic        dwait;
    logic [31:0] dload;

    int vectors = 0;
    int miscompares = 0;
    logic both_seen = 1'b0;
    logic [31:0] mem [logic [31:0]];
    logic [64:0] xlog [$];
    logic [31:0] ld;
    int cyc;

    dcache_2way_wb dut (
        .CLK(CLK), .RST(RST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt), .dhit(dhit),
        .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .dwait(dwait), .dload(dload)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder, called at the negedge: completes any transfer presented this cycle.
    task automatic mem_step();
        if (dREN && dWEN) both_seen = 1'b1;
        if (!dwait && dREN) begin
            dload = mem.exists(daddr) ? mem[daddr] : 32'h0;
            xlog.push_back({1'b0, daddr, 32'h0});
        end
        if (!dwait && dWEN) begin
            mem[daddr] = dstore;
            xlog.push_back({1'b1, daddr, dstore});
        end
    endtask

    // Holds a request until dhit (bounded); entered and left at posedge+1.
    task automatic do_req(input string tag, input logic ren, input logic wen, input logic at,
                          input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] load, output int cycles);
        logic got = 1'b0;
        dmemREN = ren; dmemWEN = wen; datomic = at; dmemaddr = addr; dmemstore = data;
        cycles = 0;
        load = 32'h0;
        xlog.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            cycles++;
            mem_step();
            if (dhit) begin
                load = dmemload;
                got = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        chk({tag, "_done"}, {64'd0, got}, 65'd1);
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    endtask

    initial begin
        RST = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0; halt = 1'b0;
        dmemaddr = 32'h0; dmemstore = 32'h0; dwait = 1'b0; dload = 32'h0;
        mem[32'h40] = 32'hDEADBEEF;
        mem[32'h44] = 32'h1;
        mem[32'hC0] = 32'h1234;
        mem[32'h7C] = 32'h55;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_dhit", dhit, 0);
        chk("rst_dmemload", dmemload, 0);
        chk("rst_flushed", flushed, 0);
        chk("rst_dren", dREN, 0);
        chk("rst_dwen", dWEN, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_dstore", dstore, 0);
        @(posedge CLK); #1;

        // Cold load: two fills then the replayed hit.
        do_req("t1", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, ld, cyc);
        chk("t1_load", ld, 32'hDEADBEEF);
        chk("t1_cycles", cyc, 4);
        chk("t1_nxfer", xlog.size(), 2);
        chk("t1_rd0", xlog[0], {1'b0, 32'h40, 32'h0});
        chk("t1_rd1", xlog[1], {1'b0, 32'h44, 32'h0});

        // Dirty eviction through LRU.
        do_req("t2sw", 1'b0, 1'b1, 1'b0, 32'h40, 32'h5, ld, cyc);
        chk("t2_sw_cycles", cyc, 1);
        do_req("t2a", 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, ld, cyc);
        chk("t2_80_cycles", cyc, 4);
        do_req("t2b", 1'b1, 1'b0, 1'b0, 32'hC0, 32'h0, ld, cyc);
        chk("t2_c0_load", ld, 32'h1234);
        chk("t2_c0_cycles", cyc, 6);
        chk("t2_nxfer", xlog.size(), 4);
        chk("t2_wb0", xlog[0], {1'b1, 32'h40, 32'h5});
        chk("t2_wb1", xlog[1], {1'b1, 32'h44, 32'h1});
        chk("t2_ld0", xlog[2], {1'b0, 32'hC0, 32'h0});
        chk("t2_ld1", xlog[3], {1'b0, 32'hC4, 32'h0});

        // LL/SC success, then SC broken by an intervening store.
        do_req("t3ll", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, ld, cyc);
        chk("t3_ll_cycles", cyc, 4);
        do_req("t3sc", 1'b0, 1'b1, 1'b1, 32'h100, 32'h7, ld, cyc);
        chk("t3_sc_ok", ld, 32'h1);
        chk("t3_sc_cycles", cyc, 1);
        do_req("t3lw", 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, ld, cyc);
        chk("t3_rd7", ld, 32'h7);
        do_req("t3ll2", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, ld, cyc);
        chk("t3_ll2_cycles", cyc, 1);
        do_req("t3sw", 1'b0, 1'b1, 1'b0, 32'h100, 32'h9, ld, cyc);
        do_req("t3sc2", 1'b0, 1'b1, 1'b1, 32'h100, 32'hA, ld, cyc);
        chk("t3_sc_fail", ld, 32'h0);
        do_req("t3lw2", 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, ld, cyc);
        chk("t3_rd9", ld, 32'h9);

        // SC without a link: immediate fail, no memory traffic.
        do_req("t4", 1'b0, 1'b1, 1'b1, 32'h200, 32'h3, ld, cyc);
        chk("t4_load", ld, 32'h0);
        chk("t4_cycles", cyc, 1);
        chk("t4_nxfer", xlog.size(), 0);

        // Make way 1 of set 7 dirty (set 0 way 1 already holds dirty 0x100).
        do_req("t5a", 1'b1, 1'b0, 1'b0, 32'h38, 32'h0, ld, cyc);
        chk("t5_38_cycles", cyc, 4);
        do_req("t5b", 1'b0, 1'b1, 1'b0, 32'h78, 32'hCAFE, ld, cyc);
        chk("t5_78_cycles", cyc, 4);
        halt = 1'b1;
        xlog.delete();
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            cyc++;
            mem_step();
            if (flushed) break;
            @(posedge CLK); #1;
        end
        chk("t5_flush_cycles", cyc, 22);
        chk("t5_nxfer", xlog.size(), 4);
        chk("t5_wb0", xlog[0], {1'b1, 32'h100, 32'h9});
        chk("t5_wb1", xlog[1], {1'b1, 32'h104, 32'h0});
        chk("t5_wb2", xlog[2], {1'b1, 32'h78, 32'hCAFE});
        chk("t5_wb3", xlog[3], {1'b1, 32'h7C, 32'h55});
        dmemREN = 1'b1; dmemaddr = 32'hC0;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("t5_flushed_nohit", dhit, 0);
        chk("t5_flushed_held", flushed, 1);
        chk("t5_flushed_dren", dREN, 0);
        @(posedge CLK); #1;
        dmemREN = 1'b0; halt = 1'b0; RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;

        // Reset in the middle of a stalled LD1.
        dmemREN = 1'b1; dmemaddr = 32'h40; dwait = 1'b0;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        mem_step();
        @(posedge CLK); #1;
        dwait = 1'b1;
        @(negedge CLK);
        chk("t6_ld1_dren", dREN, 1);
        chk("t6_ld1_daddr", daddr, 32'h44);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; dmemREN = 1'b0; dwait = 1'b0;
        @(negedge CLK);
        chk("t6_dhit", dhit, 0);
        chk("t6_dren", dREN, 0);
        chk("t6_dwen", dWEN, 0);
        chk("t6_daddr", daddr, 0);
        chk("t6_flushed", flushed, 0);
        chk("t6_dmemload", dmemload, 0);
        @(posedge CLK); #1;
        do_req("t6lw", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, ld, cyc);
        chk("t6_remiss_cycles", cyc, 4);
        chk("t6_remiss_load", ld, 32'h5);

        chk("rw_exclusive", both_seen, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
